// File: rtl/vsid_cam_commit_ctrl.sv
//------------------------------------------------------------------------------
// vsid_cam_commit_ctrl
//
// Owns the live VSID CAM image that feeds the VSID parser. Software fills a
// shadow copy entry by entry; a commit copies the whole shadow into the live
// image in one edge. The copy waits for a packet boundary on the parser input
// and then for the parser pipeline to drain, so no packet is ever classified
// against a partially updated CAM.
//
// Ports:
//   aclk, areset       clock, synchronous active-high reset
//   snoop_tvalid/      parser input AXIS handshake, observed (not driven)
//   snoop_tready/
//   snoop_tlast
//   parser_pause       registered; integrator gates parser input when 1
//   cfg_wr_*           shadow entry write (valid/ready, index, 82-bit data)
//   cfg_commit_*       commit request (valid/ready)
//   commit_done        one-cycle pulse in the APPLY cycle
//   commit_gen         count of completed commits, wraps at 256
//   vsid_cam_values    live image, entry i at [82*i +: 82]
//------------------------------------------------------------------------------
module vsid_cam_commit_ctrl #(
  parameter int AXIS_ID_WIDTH = 4,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic                                       aclk,
  input  logic                                       areset,
  input  logic                                       snoop_tvalid,
  input  logic                                       snoop_tready,
  input  logic                                       snoop_tlast,
  output logic                                       parser_pause,
  input  logic                                       cfg_wr_valid,
  output logic                                       cfg_wr_ready,
  input  logic [AXIS_ID_WIDTH-1:0]                   cfg_wr_index,
  input  logic [81:0]                                cfg_wr_data,
  input  logic                                       cfg_commit_valid,
  output logic                                       cfg_commit_ready,
  output logic                                       commit_done,
  output logic [7:0]                                 commit_gen,
  output logic [82*(2**AXIS_ID_WIDTH)-1:0]           vsid_cam_values
);

  localparam int NUM_AXIS_ID = 2 ** AXIS_ID_WIDTH;
  localparam int ENTRY_WIDTH = 82;
  localparam int IMG_W       = ENTRY_WIDTH * NUM_AXIS_ID;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EOP = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_APPLY    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               in_pkt_q, in_pkt_d;
  logic [7:0]         drain_cnt_q, drain_cnt_d;
  logic               pause_q, pause_d;
  logic               done_q, done_d;
  logic [7:0]         gen_q, gen_d;
  logic [IMG_W-1:0]   shadow_q, shadow_d;
  logic [IMG_W-1:0]   live_q, live_d;

  logic               beat;
  logic               boundary;
  logic               idle;

  always_comb begin
    state_d     = state_q;
    in_pkt_d    = in_pkt_q;
    drain_cnt_d = drain_cnt_q;
    gen_d       = gen_q;
    shadow_d    = shadow_q;
    live_d      = live_q;

    beat = snoop_tvalid && snoop_tready;
    idle = (state_q == ST_IDLE);

    // A beat always sets the packet state from its tlast, so a single-beat
    // packet leaves in_pkt at 0.
    if (beat) begin
      in_pkt_d = !snoop_tlast;
    end

    // Boundary: link between packets with nothing moving, or the last beat
    // of a packet completing right now. A packet in progress is never cut.
    boundary = (!in_pkt_q && !beat) || (beat && snoop_tlast);

    // Shadow writes are only accepted while idle, so the shadow is frozen
    // for the whole commit; a write accepted together with a commit lands
    // long before APPLY and is therefore part of that commit.
    if (cfg_wr_valid && idle) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        if (cfg_wr_index == AXIS_ID_WIDTH'(i)) begin
          shadow_d[i*ENTRY_WIDTH +: ENTRY_WIDTH] = cfg_wr_data;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_commit_valid) begin
          state_d = ST_WAIT_EOP;
        end
      end
      ST_WAIT_EOP: begin
        if (boundary) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 8'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        // Counter reaching zero ends the drain; with DRAIN_CYCLES=0 this
        // state lasts exactly one cycle.
        if (drain_cnt_q == 8'd0) begin
          state_d = ST_APPLY;
        end else begin
          drain_cnt_d = drain_cnt_q - 8'd1;
        end
      end
      ST_APPLY: begin
        live_d  = shadow_q;
        gen_d   = gen_q + 8'd1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pause and done are registered from the next state so they line up
    // exactly with DRAIN..APPLY and APPLY respectively.
    pause_d = (state_d == ST_DRAIN) || (state_d == ST_APPLY);
    done_d  = (state_d == ST_APPLY);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      in_pkt_q    <= 1'b0;
      drain_cnt_q <= 8'd0;
      pause_q     <= 1'b0;
      done_q      <= 1'b0;
      gen_q       <= 8'd0;
      shadow_q    <= '0;
      live_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      drain_cnt_q <= drain_cnt_d;
      pause_q     <= pause_d;
      done_q      <= done_d;
      gen_q       <= gen_d;
      shadow_q    <= shadow_d;
      live_q      <= live_d;
    end
  end

  assign parser_pause     = pause_q;
  assign cfg_wr_ready     = (state_q == ST_IDLE);
  assign cfg_commit_ready = (state_q == ST_IDLE);
  assign commit_done      = done_q;
  assign commit_gen       = gen_q;
  assign vsid_cam_values  = live_q;

endmodule

// File: tb/tb_vsid_cam_commit_ctrl.sv
//------------------------------------------------------------------------------
// tb_vsid_cam_commit_ctrl
//
// Scoreboard bench. A reference model follows the commit rules at transaction
// level (shadow array, packet-in-progress flag, pending commit with its
// boundary cycle) and pushes the expected image, generation and completion
// cycle when a commit's boundary is seen. A monitor pops on commit_done and
// tracks the expected live image and generation every cycle. A second
// instance with DRAIN_CYCLES=0 checks the minimal-latency case.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vsid_cam_commit_ctrl;

  localparam int AW    = 4;
  localparam int NUM   = 16;
  localparam int EW    = 82;
  localparam int IMG_W = EW * NUM;
  localparam int DRAIN = 4;

  logic             clk = 1'b0;
  logic             areset;
  logic             snoop_tvalid, snoop_tready, snoop_tlast;
  logic             parser_pause;
  logic             cfg_wr_valid, cfg_wr_ready;
  logic [AW-1:0]    cfg_wr_index;
  logic [81:0]      cfg_wr_data;
  logic             cfg_commit_valid, cfg_commit_ready;
  logic             commit_done;
  logic [7:0]       commit_gen;
  logic [IMG_W-1:0] vsid_cam_values;

  logic             zero_b;
  logic [AW-1:0]    zero_idx;
  logic [81:0]      zero_data;
  logic             pause0, wr_ready0, commit_valid0, commit_ready0, commit_done0;
  logic [7:0]       gen0;
  logic [IMG_W-1:0] live0;

  always #5 clk = ~clk;

  vsid_cam_commit_ctrl #(.AXIS_ID_WIDTH(AW), .DRAIN_CYCLES(DRAIN)) u_dut (
    .aclk(clk), .areset(areset),
    .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tlast(snoop_tlast),
    .parser_pause(parser_pause),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_index(cfg_wr_index), .cfg_wr_data(cfg_wr_data),
    .cfg_commit_valid(cfg_commit_valid), .cfg_commit_ready(cfg_commit_ready),
    .commit_done(commit_done), .commit_gen(commit_gen),
    .vsid_cam_values(vsid_cam_values)
  );

  vsid_cam_commit_ctrl #(.AXIS_ID_WIDTH(AW), .DRAIN_CYCLES(0)) u_dut0 (
    .aclk(clk), .areset(areset),
    .snoop_tvalid(zero_b), .snoop_tready(zero_b), .snoop_tlast(zero_b),
    .parser_pause(pause0),
    .cfg_wr_valid(zero_b), .cfg_wr_ready(wr_ready0),
    .cfg_wr_index(zero_idx), .cfg_wr_data(zero_data),
    .cfg_commit_valid(commit_valid0), .cfg_commit_ready(commit_ready0),
    .commit_done(commit_done0), .commit_gen(gen0),
    .vsid_cam_values(live0)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_img(string nm, logic [IMG_W-1:0] act, logic [IMG_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < NUM; i++) begin
        if (act[i*EW +: EW] !== exp[i*EW +: EW]) begin
          $display("FAIL %s entry %0d: got %h expected %h (cycle %0d)",
                   nm, i, act[i*EW +: EW], exp[i*EW +: EW], cyc);
          break;
        end
      end
    end
  endtask

  //--------------------------------------------------------------------------
  // Reference model: shadow array, packet flag, one pending commit.
  //--------------------------------------------------------------------------
  typedef struct {
    logic [IMG_W-1:0] img;
    logic [7:0]       gen;
    int               done;
  } sb_t;

  sb_t         sb[$];
  logic [81:0] shadow_m[NUM];
  bit          busy_m, bnd_seen, in_pkt_m;
  int          bnd_cyc;
  logic [7:0]  gen_m;

  function automatic logic [IMG_W-1:0] pack_shadow();
    logic [IMG_W-1:0] img;
    for (int i = 0; i < NUM; i++) img[i*EW +: EW] = shadow_m[i];
    return img;
  endfunction

  always @(negedge clk) begin
    bit   beat_m, idle_m;
    sb_t  ent;
    if (areset) begin
      busy_m = 0; bnd_seen = 0; in_pkt_m = 0; gen_m = 8'd0;
      for (int i = 0; i < NUM; i++) shadow_m[i] = '0;
      sb.delete();
    end else begin
      idle_m = !busy_m;
      chk("wr_ready", cfg_wr_ready, idle_m);
      chk("commit_ready", cfg_commit_ready, idle_m);
      chk("pause", parser_pause, busy_m && bnd_seen && (cyc > bnd_cyc));
      beat_m = snoop_tvalid && snoop_tready;
      if (busy_m && !bnd_seen) begin
        if (beat_m ? snoop_tlast : !in_pkt_m) begin
          bnd_seen = 1; bnd_cyc = cyc; gen_m = gen_m + 8'd1;
          ent.img = pack_shadow(); ent.gen = gen_m; ent.done = cyc + DRAIN + 2;
          sb.push_back(ent);
        end
      end
      if (busy_m && bnd_seen && cyc == bnd_cyc + DRAIN + 2) busy_m = 0;
      if (idle_m && cfg_wr_valid) shadow_m[cfg_wr_index] = cfg_wr_data;
      if (idle_m && cfg_commit_valid) begin busy_m = 1; bnd_seen = 0; end
      if (beat_m) in_pkt_m = !snoop_tlast;
    end
  end

  //--------------------------------------------------------------------------
  // Monitor: pops on commit_done, tracks expected live image and generation.
  //--------------------------------------------------------------------------
  logic [IMG_W-1:0] exp_live, pend_img;
  logic [7:0]       exp_gen, pend_gen;
  bit               pend;

  always @(negedge clk) begin
    sb_t e;
    if (areset) begin
      exp_live = '0; exp_gen = 8'd0; pend = 0;
    end else begin
      if (pend) begin exp_live = pend_img; exp_gen = pend_gen; pend = 0; end
      chk_img("live_image", vsid_cam_values, exp_live);
      chk("commit_gen", commit_gen, exp_gen);
      if (commit_done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done);
          pend = 1; pend_img = e.img; pend_gen = e.gen;
        end
      end else if (sb.size() > 0 && sb[0].done < cyc) begin
        e = sb.pop_front();
        chk("done_missing", 0, 1);
      end
    end
  end

  //--------------------------------------------------------------------------
  // DRAIN_CYCLES=0 instance: APPLY two cycles after acceptance + 1.
  //--------------------------------------------------------------------------
  bit         busy0;
  int         acc0;
  logic [7:0] gen0_m;

  always @(negedge clk) begin
    if (areset) begin
      busy0 = 0; gen0_m = 8'd0;
    end else begin
      chk("d0_ready", commit_ready0, !busy0);
      chk("d0_pause", pause0, busy0 && (cyc >= acc0 + 2));
      chk("d0_done", commit_done0, busy0 && (cyc == acc0 + 3));
      chk("d0_gen", gen0, gen0_m);
      chk_img("d0_live", live0, '0);
      if (busy0 && cyc == acc0 + 3) begin busy0 = 0; gen0_m = gen0_m + 8'd1; end
      else if (!busy0 && commit_valid0) begin busy0 = 1; acc0 = cyc; end
    end
  end

  //--------------------------------------------------------------------------
  // Handshake samples for the drivers (taken before each active edge).
  //--------------------------------------------------------------------------
  bit wr_ok_s, cm_ok_s, cm0_ok_s;
  always @(negedge clk) begin
    wr_ok_s  = cfg_wr_valid && cfg_wr_ready;
    cm_ok_s  = cfg_commit_valid && cfg_commit_ready;
    cm0_ok_s = commit_valid0 && commit_ready0;
  end

  //--------------------------------------------------------------------------
  // Packet driver: plays lengths from pkt_q; tready is gated by pause as
  // the integrator would do.
  //--------------------------------------------------------------------------
  int pkt_q[$];
  int cur_len, cur_idx;
  bit rand_gaps, rand_rdy;

  initial begin
    bit beat_d;
    cur_len = 0; cur_idx = 0;
    snoop_tvalid = 0; snoop_tready = 0; snoop_tlast = 0;
    forever begin
      @(posedge clk); #1;
      beat_d = snoop_tvalid && snoop_tready;
      if (beat_d) begin
        cur_idx++;
        if (cur_idx == cur_len) begin cur_len = 0; cur_idx = 0; end
      end
      if (cur_len == 0 && pkt_q.size() > 0) begin cur_len = pkt_q.pop_front(); cur_idx = 0; end
      if (cur_len == 0) snoop_tvalid = 0;
      else if (beat_d || !snoop_tvalid) snoop_tvalid = rand_gaps ? ($urandom % 4 != 0) : 1'b1;
      snoop_tlast  = (cur_len != 0) && (cur_idx == cur_len - 1);
      snoop_tready = (rand_rdy ? ($urandom % 4 != 0) : 1'b1) && !parser_pause;
    end
  end

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [81:0] rand82();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[81:0];
  endfunction

  task automatic do_write(input logic [AW-1:0] idx, input logic [81:0] d);
    int n = 0;
    cfg_wr_valid = 1; cfg_wr_index = idx; cfg_wr_data = d;
    do begin tick(); n++; end while (!wr_ok_s && n < 200);
    if (!wr_ok_s) chk("wr_accept_timeout", 0, 1);
    cfg_wr_valid = 0;
  endtask

  task automatic do_commit();
    int n = 0;
    cfg_commit_valid = 1;
    do begin tick(); n++; end while (!cm_ok_s && n < 200);
    if (!cm_ok_s) chk("commit_accept_timeout", 0, 1);
    cfg_commit_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cfg_commit_ready && sb.size() == 0 && cur_len == 0 && pkt_q.size() == 0) && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
    tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [81:0] v3;
    areset = 1; zero_b = 0; zero_idx = '0; zero_data = '0; commit_valid0 = 0;
    cfg_wr_valid = 0; cfg_wr_index = '0; cfg_wr_data = '0; cfg_commit_valid = 0;
    rand_gaps = 0; rand_rdy = 0;
    repeat (3) tick();
    areset = 0;
    tick();

    // Reset state
    chk("rst_pause", parser_pause, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_gen", commit_gen, 0);
    chk("rst_wr_ready", cfg_wr_ready, 1);
    chk_img("rst_live", vsid_cam_values, '0);

    // Single write + commit on an idle link: APPLY at t+7, pause 6 cycles
    v3 = {2'b01, 48'h0A0B0C0D0E0F, 32'h12345678};
    do_write(4'd3, v3);
    do_commit();                    // now in cycle t+1
    repeat (5) tick();              // t+6: still draining
    chk("t1_pause_drain", parser_pause, 1);
    chk("t1_entry3_before", vsid_cam_values[3*EW +: EW], 82'd0);
    tick();                         // t+7: APPLY
    chk("t1_done_pulse", commit_done, 1);
    chk("t1_entry3_apply", vsid_cam_values[3*EW +: EW], 82'd0);
    tick();                         // t+8: live image visible
    chk("t1_entry3_after", vsid_cam_values[3*EW +: EW], v3);
    chk("t1_gen", commit_gen, 8'd1);
    chk("t1_pause_off", parser_pause, 0);
    chk("t1_done_off", commit_done, 0);
    wait_idle();

    // Commit accepted on beat 2 of a 10-beat packet
    do_write(4'd7, rand82());
    pkt_q.push_back(10);
    begin
      int n = 0;
      while (!(cur_len == 10 && cur_idx == 1) && n < 50) begin tick(); n++; end
      if (n >= 50) chk("pkt_start_timeout", 0, 1);
    end
    cfg_commit_valid = 1;
    tick();
    cfg_commit_valid = 0;
    wait_idle();

    // Single-beat packet in the WAIT_EOP entry cycle
    do_write(4'd9, rand82());
    cfg_commit_valid = 1;
    pkt_q.push_back(1);
    tick();
    cfg_commit_valid = 0;
    wait_idle();

    // Write + commit in the same cycle to index 15; then a write held
    // through WAIT_EOP that lands only after the return to IDLE
    cfg_wr_valid = 1; cfg_wr_index = 4'd15; cfg_wr_data = rand82();
    cfg_commit_valid = 1;
    tick();
    cfg_wr_valid = 0; cfg_commit_valid = 0;
    chk("wr_ready_busy", cfg_wr_ready, 0);
    do_write(4'd5, rand82());
    do_commit();
    wait_idle();

    // Randomized traffic, writes and commits
    rand_gaps = 1; rand_rdy = 1;
    for (int i = 0; i < 600; i++) begin
      if (cur_len == 0 && pkt_q.size() == 0 && ($urandom % 3 == 0))
        pkt_q.push_back(int'($urandom_range(1, 8)));
      if (!cfg_wr_valid || wr_ok_s) begin
        cfg_wr_valid = ($urandom % 4 == 0);
        cfg_wr_index = AW'($urandom);
        cfg_wr_data  = rand82();
      end
      if (!cfg_commit_valid || cm_ok_s) cfg_commit_valid = ($urandom % 12 == 0);
      tick();
    end
    cfg_wr_valid = 0; cfg_commit_valid = 0;
    wait_idle();
    rand_gaps = 0; rand_rdy = 0;

    // Reset in the middle of DRAIN
    do_write(4'd2, rand82());
    do_commit();                    // cycle t+1
    tick(); tick();                 // t+3: DRAIN
    chk("rst_drain_pause_pre", parser_pause, 1);
    areset = 1;
    tick();
    areset = 0;
    chk("rst_drain_pause", parser_pause, 0);
    chk("rst_drain_done", commit_done, 0);
    chk_img("rst_drain_live", vsid_cam_values, '0);
    chk("rst_drain_gen", commit_gen, 8'd0);
    tick();

    // 256 back-to-back commits after reset: generation wraps to 0
    do_write(4'd11, rand82());
    for (int i = 0; i < 256; i++) do_commit();
    wait_idle();
    chk("gen_wrap", commit_gen, 8'd0);

    // DRAIN_CYCLES=0 instance
    for (int i = 0; i < 5; i++) begin
      int n = 0;
      commit_valid0 = 1;
      do begin tick(); n++; end while (!cm0_ok_s && n < 50);
      if (!cm0_ok_s) chk("d0_accept_timeout", 0, 1);
      commit_valid0 = 0;
    end
    repeat (6) tick();
    chk("d0_gen_final", gen0, 8'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vsid_cam_commit_ctrl.md
Name: vsid_cam_commit_ctrl

Overview:
- Owns the live VSID CAM image, a packed vector of NUM_AXIS_ID entries of 82 bits each, that feeds the VSID parser's vsid_cam_values input.
- Software writes entries into a shadow copy. A commit request copies the whole shadow into the live image atomically.
- The copy happens only at a packet boundary, after the parser pipeline has drained, so no packet is ever classified against a half-updated CAM.
- The block snoops the parser's input AXIS handshake and drives a pause signal that gates the parser's input between packets.

Parameters:
- AXIS_ID_WIDTH, 4: ID width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH entries.
- DRAIN_CYCLES, 4: cycles to wait after a boundary before applying. Covers parser latency plus RETIMING_STAGES. Range 0..255.
- ENTRY_WIDTH, 82 (localparam): 32 VSID + 48 DA MAC + 2 flags.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- snoop_tvalid  in  1  parser input tvalid, observed before gating.
- snoop_tready  in  1  parser input tready.
- snoop_tlast  in  1  parser input tlast.
- parser_pause  out  1  when 1, the integrator forces parser input tvalid and upstream tready to 0.
- cfg_wr_valid  in  1  shadow write request.
- cfg_wr_ready  out  1  write accepted when valid&&ready.
- cfg_wr_index  in  AXIS_ID_WIDTH  entry index.
- cfg_wr_data  in  82  entry: [31:0] VSID, [79:32] DA MAC, [81:80] flags.
- cfg_commit_valid  in  1  commit request.
- cfg_commit_ready  out  1  commit accepted when valid&&ready.
- commit_done  out  1  one-cycle pulse in the cycle the live image updates.
- commit_gen  out  8  count of completed commits.
- vsid_cam_values  out  82*NUM_AXIS_ID  live image; entry i at [82*i +: 82].

Behaviour:
- Reset, synchronous on areset=1:
  - shadow and live images = 0; state = IDLE; in_pkt = 0; drain counter = 0.
  - parser_pause = 0; commit_done = 0; commit_gen = 0.
  - A commit pending at reset is discarded.
- Packet tracking, using beat = snoop_tvalid && snoop_tready:
  - in_pkt is set on a beat with tlast=0.
  - in_pkt is cleared on a beat with tlast=1.
  - A single-beat packet leaves in_pkt at 0.
- cfg_wr_ready = 1 only in IDLE. An accepted write updates shadow[cfg_wr_index] on the next edge. The live image is unaffected.
- cfg_commit_ready = 1 only in IDLE. A write and a commit accepted in the same cycle: the write is included in that commit.
- FSM:
  - IDLE: on accepted commit -> WAIT_EOP.
  - WAIT_EOP:
    - Boundary condition: in_pkt=0 and no beat this cycle, or a beat with tlast=1 this cycle.
    - On the boundary, go to DRAIN and load counter = DRAIN_CYCLES.
    - A packet in progress is never cut: pause is not asserted while in_pkt=1.
  - DRAIN: counter decrements each cycle. When the counter is 0, go to APPLY. With DRAIN_CYCLES=0, DRAIN lasts exactly one cycle.
  - APPLY: live <= shadow (all entries, one edge); commit_done = 1 for this cycle; commit_gen += 1, wrapping 255->0; then -> IDLE.
- parser_pause:
  - Registered.
  - Asserted from the cycle after the WAIT_EOP boundary through the APPLY cycle inclusive. Deasserted in the cycle after APPLY, i.e. back in IDLE.
  - If snoop_tvalid is observed while paused (gating bypassed), the block still tracks it. Correctness is the integrator's responsibility.
- Commit latency with an idle link: accept at cycle t -> WAIT_EOP at t+1 -> DRAIN at t+2. APPLY at t+3+DRAIN_CYCLES; the live image is visible the cycle after.
- vsid_cam_values is a direct register output and changes only on the APPLY edge or reset.

Test Plan:
- Reset then idle: write index 3 = {flags 2'b01, MAC 0x0A0B0C0D0E0F, VSID 0x12345678}; commit with DRAIN_CYCLES=4.
  - Live entry 3 stays 0 until the APPLY edge, t+7; then reads exactly that value.
  - commit_done pulses once; commit_gen = 1; pause high for 6 cycles.
- Commit accepted mid-packet (beat 2 of a 10-beat packet):
  - pause stays 0 until the tlast beat.
  - DRAIN starts the cycle after tlast; the live image changes only after it.
  - No beats are accepted while pause=1.
- Single-beat packet (tlast on the first beat) in the same cycle as WAIT_EOP entry:
  - Treated as a boundary; DRAIN entered the next cycle.
- Write and commit in the same cycle to index 15:
  - Entry 15 is included in the commit.
  - A write attempted during WAIT_EOP sees cfg_wr_ready=0 and lands only after the return to IDLE.
- 256 back-to-back commits: commit_gen wraps to 0. DRAIN_CYCLES=0 yields APPLY one cycle after DRAIN.
- areset during DRAIN:
  - Live and shadow images = 0; pause drops the next cycle; no commit_done.
  - The next commit after reset works normally.
